// File: rtl/lattice_boundary_scanner.sv
// Raster scanner for an NX x NY lattice: one classified node per handshake.
// Emits coordinates, linear address and a one-hot boundary class per node.
module lattice_boundary_scanner #(
  parameter int NX = 16,
  parameter int NY = 16,
  parameter int XW = $clog2(NX),
  parameter int YW = $clog2(NY),
  parameter int AW = $clog2(NX * NY)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          lid_en,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [XW-1:0] out_x,
  output logic [YW-1:0] out_y,
  output logic [AW-1:0] out_addr,
  output logic          out_last,
  output logic          lid,
  output logic          top_wall,
  output logic          bottom_wall,
  output logic          left_wall,
  output logic          right_wall,
  output logic          interior,
  output logic          busy,
  output logic          done
);

  typedef enum logic {IDLE, SCAN} state_t;

  localparam logic [XW-1:0] XMAX = XW'(NX - 1);
  localparam logic [YW-1:0] YMAX = YW'(NY - 1);

  state_t        state, state_n;
  logic [1:0]    rs;
  logic          rst_i;
  logic [XW-1:0] x_q, x_n;
  logic [YW-1:0] y_q, y_n;
  logic [AW-1:0] addr_q, addr_n;
  logic          last_q, last_n;
  logic [5:0]    cls_q, cls_n;
  logic          lidm_q, lidm_n;
  logic          done_q, done_n;

  // Flags packed as {lid, top, bottom, left, right, interior}.
  function automatic logic [5:0] classify(
    input logic [XW-1:0] x,
    input logic [YW-1:0] y,
    input logic          lm
  );
    if (y == YMAX && x != '0 && x != XMAX)
      classify = lm ? 6'b100000 : 6'b010000;
    else if (y == '0)
      classify = 6'b001000;
    else if (x == '0)
      classify = 6'b000100;
    else if (x == XMAX)
      classify = 6'b000010;
    else
      classify = 6'b000001;
  endfunction

  // Release of reset is brought onto the clock before the core sees it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rs <= 2'b00;
    else        rs <= {rs[0], 1'b1};
  end

  assign rst_i = rs[1];

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      state  <= IDLE;
      x_q    <= '0;
      y_q    <= '0;
      addr_q <= '0;
      last_q <= 1'b0;
      cls_q  <= '0;
      lidm_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      x_q    <= x_n;
      y_q    <= y_n;
      addr_q <= addr_n;
      last_q <= last_n;
      cls_q  <= cls_n;
      lidm_q <= lidm_n;
      done_q <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    x_n     = x_q;
    y_n     = y_q;
    addr_n  = addr_q;
    last_n  = last_q;
    cls_n   = cls_q;
    lidm_n  = lidm_q;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = SCAN;
          lidm_n  = lid_en;
          x_n     = '0;
          y_n     = '0;
          addr_n  = '0;
          last_n  = 1'b0;
          cls_n   = classify('0, '0, lid_en);
        end
      end
      SCAN: begin
        if (out_ready) begin
          if (last_q) begin
            state_n = IDLE;
            x_n     = '0;
            y_n     = '0;
            addr_n  = '0;
            last_n  = 1'b0;
            cls_n   = '0;
            done_n  = 1'b1;
          end else begin
            addr_n = addr_q + 1'b1;
            if (x_q == XMAX) begin
              x_n = '0;
              y_n = y_q + 1'b1;
            end else begin
              x_n = x_q + 1'b1;
            end
            last_n = (x_n == XMAX) && (y_n == YMAX);
            cls_n  = classify(x_n, y_n, lidm_q);
          end
        end
      end
    endcase
  end

  assign out_valid   = (state == SCAN);
  assign busy        = (state == SCAN);
  assign out_x       = x_q;
  assign out_y       = y_q;
  assign out_addr    = addr_q;
  assign out_last    = last_q;
  assign lid         = cls_q[5];
  assign top_wall    = cls_q[4];
  assign bottom_wall = cls_q[3];
  assign left_wall   = cls_q[2];
  assign right_wall  = cls_q[1];
  assign interior    = cls_q[0];
  assign done        = done_q;

endmodule

// File: tb/tb_lattice_boundary_scanner.sv
// Bench for lattice_boundary_scanner: 16x16 and 5x3 instances against
// an index-based reference model plus hand-computed literal checks.
module tb_lattice_boundary_scanner;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic       a_start = 0, a_lid = 0, a_rdy = 1;
  logic       a_valid, a_last, a_lidf, a_top, a_bot, a_left, a_right, a_int;
  logic       a_busy, a_done;
  logic [3:0] a_x, a_y;
  logic [7:0] a_addr;

  logic       b_start = 0, b_lid = 0, b_rdy = 1;
  logic       b_valid, b_last, b_lidf, b_top, b_bot, b_left, b_right, b_int;
  logic       b_busy, b_done;
  logic [2:0] b_x;
  logic [1:0] b_y;
  logic [3:0] b_addr;

  lattice_boundary_scanner #(.NX(16), .NY(16)) u_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .lid_en(a_lid),
    .out_ready(a_rdy), .out_valid(a_valid), .out_x(a_x), .out_y(a_y),
    .out_addr(a_addr), .out_last(a_last), .lid(a_lidf),
    .top_wall(a_top), .bottom_wall(a_bot), .left_wall(a_left),
    .right_wall(a_right), .interior(a_int), .busy(a_busy), .done(a_done)
  );

  lattice_boundary_scanner #(.NX(5), .NY(3)) u_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .lid_en(b_lid),
    .out_ready(b_rdy), .out_valid(b_valid), .out_x(b_x), .out_y(b_y),
    .out_addr(b_addr), .out_last(b_last), .lid(b_lidf),
    .top_wall(b_top), .bottom_wall(b_bot), .left_wall(b_left),
    .right_wall(b_right), .interior(b_int), .busy(b_busy), .done(b_done)
  );

  wire [5:0] a_fl = {a_lidf, a_top, a_bot, a_left, a_right, a_int};
  wire [5:0] b_fl = {b_lidf, b_top, b_bot, b_left, b_right, b_int};
  wire [25:0] a_vec = {a_valid, a_x, a_y, a_addr, a_last, a_fl,
                       a_busy, a_done};
  wire [18:0] b_vec = {b_valid, b_x, b_y, b_addr, b_last, b_fl,
                       b_busy, b_done};

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
               $time);
    end
  endtask

  // Class of node (x,y) straight from the boundary rules.
  function automatic logic [5:0] cls(input int x, input int y,
                                     input int nx, input int ny,
                                     input bit lm);
    if (y == ny - 1 && x >= 1 && x <= nx - 2) return lm ? 6'b100000
                                                         : 6'b010000;
    if (y == 0) return 6'b001000;
    if (x == 0) return 6'b000100;
    if (x == nx - 1) return 6'b000010;
    return 6'b000001;
  endfunction

  // Model: scan position is a node index k; x = k % NX, y = k / NX.
  bit ma_act = 0, ma_lm = 0, ma_dn = 0;
  int ma_k = 0;
  bit mb_act = 0, mb_lm = 0, mb_dn = 0;
  int mb_k = 0;
  int rel = 0;

  task automatic step(input int nx, input int ny, input bit st,
                      input bit lid, input bit rdy, inout bit act,
                      inout int k, inout bit lm, inout bit dn);
    dn = 0;
    if (!act) begin
      if (st) begin
        act = 1; k = 0; lm = lid;
      end
    end else if (rdy) begin
      if (k == nx * ny - 1) begin
        act = 0; k = 0; dn = 1;
      end else begin
        k++;
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma_act = 0; ma_dn = 0; ma_k = 0;
      mb_act = 0; mb_dn = 0; mb_k = 0;
      rel = 0;
    end else if (rel >= 2) begin
      step(16, 16, a_start, a_lid, a_rdy, ma_act, ma_k, ma_lm, ma_dn);
      step(5, 3, b_start, b_lid, b_rdy, mb_act, mb_k, mb_lm, mb_dn);
    end else begin
      rel++;
    end
  end

  logic [18:0] b_prev = '0;
  bit          b_stall = 0;

  always @(negedge clk) begin
    logic [25:0] ea;
    logic [18:0] eb;
    if (ma_act)
      ea = {1'b1, 4'(ma_k % 16), 4'(ma_k / 16), 8'(ma_k), ma_k == 255,
            cls(ma_k % 16, ma_k / 16, 16, 16, ma_lm), 1'b1, ma_dn};
    else
      ea = {25'b0, ma_dn};
    if (mb_act)
      eb = {1'b1, 3'(mb_k % 5), 2'(mb_k / 5), 4'(mb_k), mb_k == 14,
            cls(mb_k % 5, mb_k / 5, 5, 3, mb_lm), 1'b1, mb_dn};
    else
      eb = {18'b0, mb_dn};
    check("nodeA", 64'(a_vec), 64'(ea));
    check("nodeB", 64'(b_vec), 64'(eb));
    if (a_valid) check("onehotA", 64'($countones(a_fl)), 64'd1);
    if (b_valid) check("onehotB", 64'($countones(b_fl)), 64'd1);
    if (b_stall && rst_n) check("stallB", 64'(b_vec), 64'(b_prev));
    b_prev  = b_vec;
    b_stall = b_valid && !b_rdy && rst_n;
  end

  int nodes, lastn, last_cyc, done_cyc;
  int cnt[6];
  logic [25:0] first_vec;

  task automatic start_a(input bit lid);
    @(posedge clk); #1;
    a_start = 1; a_lid = lid;
    @(posedge clk); #1;
    a_start = 0;
  endtask

  // Called in cycle 1 of a scan (the cycle after the accepting edge).
  task automatic run_a(input int toggle_at);
    nodes = 0; lastn = 0; last_cyc = -1; done_cyc = -1;
    foreach (cnt[i]) cnt[i] = 0;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      if (c == 1) first_vec = a_vec;
      if (c == toggle_at) a_lid = ~a_lid;
      if (a_valid) begin
        nodes++;
        for (int i = 0; i < 6; i++) cnt[i] += int'(a_fl[5-i]);
      end
      if (a_last) begin lastn++; last_cyc = c; end
      if (a_done) begin done_cyc = c; break; end
      @(posedge clk); #1;
    end
    if (done_cyc < 0) check("timeoutA", 64'd0, 64'd1);
  endtask

  task automatic run_b(input bit lid);
    int hs;
    bit seen;
    hs = 0; seen = 0;
    @(posedge clk); #1;
    b_start = 1; b_lid = lid;
    @(posedge clk); #1;
    b_start = 0;
    for (int c = 0; c < 300; c++) begin
      b_rdy = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (b_valid && b_rdy) hs++;
      if (b_done) begin seen = 1; break; end
      @(posedge clk); #1;
    end
    b_rdy = 1;
    check("doneB", 64'(seen), 64'd1);
    check("handshakesB", 64'(hs), 64'd15);
  endtask

  initial begin
    int hs;
    #1 rst_n = 0;
    @(negedge clk);
    check("resetA", 64'(a_vec), 64'd0);
    check("resetB", 64'(b_vec), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    repeat (10) @(negedge clk);
    check("idleA", 64'(a_vec), 64'd0);

    // Full 16x16 scan, moving lid.
    start_a(1);
    run_a(0);
    check("firstA", 64'(first_vec), 64'({1'b1, 16'd0, 1'b0,
                                          6'b001000, 1'b1, 1'b0}));
    check("nodesA", 64'(nodes), 64'd256);
    check("lidA", 64'(cnt[0]), 64'd14);
    check("topA", 64'(cnt[1]), 64'd0);
    check("botA", 64'(cnt[2]), 64'd16);
    check("leftA", 64'(cnt[3]), 64'd15);
    check("rightA", 64'(cnt[4]), 64'd15);
    check("intA", 64'(cnt[5]), 64'd196);
    check("lastCntA", 64'(lastn), 64'd1);
    check("lastCycA", 64'(last_cyc), 64'd256);
    check("doneCycA", 64'(done_cyc), 64'd257);

    // Static wall, lid_en toggled mid-scan.
    repeat (3) @(posedge clk);
    start_a(0);
    run_a(100);
    check("wallLidA", 64'(cnt[0]), 64'd0);
    check("wallTopA", 64'(cnt[1]), 64'd14);
    a_lid = 0;

    // 5x3 under random back-pressure.
    run_b(1);
    run_b(0);

    // start during SCAN ignored, start in done cycle accepted.
    start_a(1);
    repeat (10) @(posedge clk);
    #1 a_start = 1;
    @(posedge clk); #1;
    a_start = 0;
    @(negedge clk);
    check("ignoreStartA", 64'(a_addr), 64'd11);
    begin
      bit seen;
      seen = 0;
      for (int c = 0; c < 400; c++) begin
        if (a_done) begin seen = 1; break; end
        @(negedge clk);
      end
      check("doneSeenA", 64'(seen), 64'd1);
    end
    a_start = 1;
    @(posedge clk); #1;
    a_start = 0;
    @(negedge clk);
    check("restart00A", 64'({a_valid, a_x, a_y, a_addr}),
          64'({1'b1, 16'd0}));

    // Reset after 40 handshakes.
    hs = 0;
    for (int c = 0; c < 100; c++) begin
      if (a_valid && a_rdy) hs++;
      if (hs == 40) break;
      @(posedge clk);
      @(negedge clk);
    end
    @(posedge clk); #1;
    rst_n = 0;
    #1 check("rstAsyncA", 64'(a_vec), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    repeat (5) @(posedge clk);
    start_a(1);
    run_a(0);
    check("afterRst00A", 64'(first_vec), 64'({1'b1, 16'd0, 1'b0,
                                               6'b001000, 1'b1, 1'b0}));
    check("afterRstNodesA", 64'(nodes), 64'd256);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
